// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// memory op codes, stall encodings and FSM states.
package mem_access_ctrl_pkg;

    localparam logic [7:0] EXE_NOP_OP = 8'h00;
    localparam logic [7:0] EXE_LB_OP  = 8'hE0;
    localparam logic [7:0] EXE_LH_OP  = 8'hE1;
    localparam logic [7:0] EXE_LW_OP  = 8'hE3;
    localparam logic [7:0] EXE_LBU_OP = 8'hE4;
    localparam logic [7:0] EXE_LHU_OP = 8'hE5;
    localparam logic [7:0] EXE_SB_OP  = 8'hE8;
    localparam logic [7:0] EXE_SH_OP  = 8'hE9;
    localparam logic [7:0] EXE_SW_OP  = 8'hEB;

    localparam logic Stop   = 1'b1;
    localparam logic Nostop = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_ABORT = 2'd3
    } state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational little-endian lane logic: byte-select and store replication for
// the incoming op, plus extraction/extension of the returned word for the latched op.
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [7:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic        o_is_mem,
    output logic        o_is_load,
    output logic        o_misaligned,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    input  logic [7:0]  i_ld_op,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = i_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_lane[i_ld_addr_lo];
    assign w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_is_mem     = is_load_op(i_op) || is_store_op(i_op);
        o_is_load    = is_load_op(i_op);
        o_misaligned = 1'b0;
        o_sel        = 4'b0000;
        o_wdata      = i_wdata;
        case (i_op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
                o_sel   = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
                o_sel        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            EXE_LW_OP, EXE_SW_OP: begin
                o_sel        = 4'b1111;
                o_misaligned = |i_addr_lo;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_rdata = i_rdata;
        case (i_ld_op)
            EXE_LB_OP:  o_rdata = {{24{w_byte[7]}}, w_byte};
            EXE_LBU_OP: o_rdata = {24'h0, w_byte};
            EXE_LH_OP:  o_rdata = {{16{w_half[15]}}, w_half};
            EXE_LHU_OP: o_rdata = {16'h0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: req/ack bus handshake with stall, flush
// and misalignment handling. Optional bus timeout enabled by MEM_BUS_TIMEOUT_EN.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall_i,
    input  logic [7:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        stall_req_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o
);

    state_e      r_state, w_state_next;
    logic        r_bus_req, r_bus_we;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_addr, r_bus_wdata, r_rdata;
    logic [7:0]  r_ld_op;
    logic [1:0]  r_ld_addr_lo;

    logic        w_is_mem, w_is_load, w_misaligned;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata, w_rdata_ext, w_rdata_next;
    logic        w_issue, w_bus_req_next, w_timeout;
    logic        w_stall_req, w_rdata_valid, w_adel, w_ades;

    mem_lane_align u_align (
        .i_op         (mem_op_i),
        .i_addr_lo    (mem_addr_i[1:0]),
        .i_wdata      (mem_wdata_i),
        .o_is_mem     (w_is_mem),
        .o_is_load    (w_is_load),
        .o_misaligned (w_misaligned),
        .o_sel        (w_sel),
        .o_wdata      (w_wdata),
        .i_ld_op      (r_ld_op),
        .i_ld_addr_lo (r_ld_addr_lo),
        .i_rdata      (bus_rdata_i),
        .o_rdata      (w_rdata_ext)
    );

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;

    // Counter restarts whenever the FSM changes state, so BUSY->ABORT gets a fresh budget.
    always_ff @(posedge clk) begin
        if (!rst || (w_state_next != r_state)) begin
            r_cnt <= '0;
        end else if (r_state == S_BUSY || r_state == S_ABORT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
        end
    end

    assign w_timeout = (r_state == S_BUSY || r_state == S_ABORT) && !bus_ack_i &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err_o = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_issue        = 1'b0;
        w_bus_req_next = r_bus_req;
        w_rdata_next   = r_rdata;
        w_stall_req    = Nostop;
        w_rdata_valid  = 1'b0;
        w_adel         = 1'b0;
        w_ades         = 1'b0;
        if (rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_mem) begin
                        if (w_misaligned) begin
                            w_adel = w_is_load;
                            w_ades = !w_is_load;
                        end else if (!flush) begin
                            w_issue        = 1'b1;
                            w_bus_req_next = 1'b1;
                            w_stall_req    = Stop;
                            w_state_next   = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    w_stall_req = flush ? Nostop : Stop;
                    if (bus_ack_i) begin
                        w_bus_req_next = 1'b0;
                        if (flush) begin
                            w_state_next = S_IDLE;
                        end else begin
                            w_rdata_next = w_rdata_ext;
                            w_state_next = S_DONE;
                        end
                    end else if (w_timeout) begin
                        w_bus_req_next = 1'b0;
                        w_rdata_next   = '0;
                        w_state_next   = flush ? S_IDLE : S_DONE;
                    end else if (flush) begin
                        w_state_next = S_ABORT;
                    end
                end
                S_DONE: begin
                    w_rdata_valid = is_load_op(r_ld_op);
                    if (!stall_i || flush) begin
                        w_state_next = S_IDLE;
                    end
                end
                S_ABORT: begin
                    // The bus cannot cancel, so keep requesting until it completes.
                    if (bus_ack_i || w_timeout) begin
                        w_bus_req_next = 1'b0;
                        w_state_next   = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_sel    <= 4'b0000;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_rdata      <= '0;
            r_ld_op      <= EXE_NOP_OP;
            r_ld_addr_lo <= 2'b00;
        end else begin
            r_bus_req <= w_bus_req_next;
            r_rdata   <= w_rdata_next;
            if (w_issue) begin
                r_bus_we     <= !w_is_load;
                r_bus_sel    <= w_sel;
                r_bus_addr   <= {mem_addr_i[31:2], 2'b00};
                r_bus_wdata  <= w_wdata;
                r_ld_op      <= mem_op_i;
                r_ld_addr_lo <= mem_addr_i[1:0];
            end
        end
    end

    assign stall_req_o   = w_stall_req;
    assign rdata_o       = r_rdata;
    assign rdata_valid_o = w_rdata_valid;
    assign adel_o        = w_adel;
    assign ades_o        = w_ades;
    assign bus_req_o     = r_bus_req;
    assign bus_we_o      = r_bus_we;
    assign bus_sel_o     = r_bus_sel;
    assign bus_addr_o    = r_bus_addr;
    assign bus_wdata_o   = r_bus_wdata;

endmodule
